// File: rtl/fwb_master.sv
// Passive Wishbone pipelined-master protocol monitor: counts requests/responses
// and raises sticky fault flags when the master or slave breaks bus rules.
module fwb_master #(
  parameter int unsigned AW                   = 32,
  parameter int unsigned DW                   = 32,
  parameter int unsigned F_LGDEPTH            = 4,
  parameter int unsigned F_MAX_STALL          = 0,
  parameter int unsigned F_MAX_ACK_DELAY      = 0,
  parameter int unsigned F_OPT_RMW_BUS_OPTION = 1,
  parameter int unsigned F_OPT_DISCONTINUOUS  = 0
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  input  logic                 i_wb_ack,
  input  logic                 i_wb_stall,
  input  logic [DW-1:0]        i_wb_idata,
  input  logic                 i_wb_err,
  output logic [F_LGDEPTH-1:0] f_nreqs,
  output logic [F_LGDEPTH-1:0] f_nacks,
  output logic [F_LGDEPTH-1:0] f_outstanding,
  output logic                 o_mfault,
  output logic                 o_sfault
);

  logic                 accept, resp;
  logic                 mviol, sviol;
  logic [F_LGDEPTH-1:0] nreqs = '0;
  logic [F_LGDEPTH-1:0] nacks = '0;
  logic [31:0]          stall_cnt = '0;
  logic [31:0]          ackwait_cnt = '0;
  logic                 mfault = 1'b0;
  logic                 sfault = 1'b0;

  logic                 past_reset = 1'b0;
  logic                 past_cyc = 1'b0;
  logic                 past_stb = 1'b0;
  logic                 past_stall = 1'b0;
  logic                 past_we = 1'b0;
  logic                 past_cyc_err = 1'b0;
  logic [AW-1:0]        past_addr = '0;
  logic [DW-1:0]        past_data = '0;
  logic [DW/8-1:0]      past_sel = '0;
  logic                 had_stb = 1'b0;
  logic                 stb_fell = 1'b0;
  logic                 req_seen = 1'b0;
  logic                 req_we = 1'b0;
  logic                 past_stalled;

  logic unused_idata;
  assign unused_idata = ^i_wb_idata;

  assign accept       = i_wb_cyc && i_wb_stb && !i_wb_stall;
  assign resp         = i_wb_cyc && (i_wb_ack || i_wb_err);
  assign past_stalled = past_cyc && past_stb && past_stall && !past_reset;

  assign f_nreqs  = nreqs;
  assign f_nacks  = nacks;
  assign o_mfault = mfault;
  assign o_sfault = sfault;

  always_comb begin
    f_outstanding = '0;
    if (i_wb_cyc)
      f_outstanding = nreqs - nacks;
  end

  always_comb begin
    mviol = 1'b0;
    if (i_wb_stb && !i_wb_cyc)
      mviol = 1'b1;
    if (past_reset && (i_wb_cyc || i_wb_stb))
      mviol = 1'b1;
    if (past_stalled) begin
      if (!i_wb_stb || (i_wb_addr != past_addr) || (i_wb_we != past_we)
          || (i_wb_sel != past_sel))
        mviol = 1'b1;
      if (past_we && (i_wb_data != past_data))
        mviol = 1'b1;
    end
    if (i_wb_cyc && i_wb_stb && req_seen && (i_wb_we != req_we))
      mviol = 1'b1;
    if ((F_OPT_DISCONTINUOUS == 0) && i_wb_cyc && i_wb_stb && stb_fell)
      mviol = 1'b1;
    if ((F_OPT_RMW_BUS_OPTION == 0) && past_cyc_err && !past_reset && i_wb_cyc)
      mviol = 1'b1;
    if (nreqs == '1)
      mviol = 1'b1;
  end

  always_comb begin
    sviol = 1'b0;
    if (past_reset && (i_wb_ack || i_wb_err))
      sviol = 1'b1;
    if (i_wb_ack && i_wb_err)
      sviol = 1'b1;
    if (!past_cyc && (i_wb_ack || i_wb_err))
      sviol = 1'b1;
    if (resp && (f_outstanding == '0))
      sviol = 1'b1;
    if (nacks > nreqs)
      sviol = 1'b1;
    if ((F_MAX_STALL > 0) && (stall_cnt > F_MAX_STALL))
      sviol = 1'b1;
    if ((F_MAX_ACK_DELAY > 0) && (ackwait_cnt > F_MAX_ACK_DELAY))
      sviol = 1'b1;
  end

  always_ff @(posedge i_clk) begin
    past_reset   <= i_reset;
    past_cyc     <= i_wb_cyc;
    past_stb     <= i_wb_stb;
    past_stall   <= i_wb_stall;
    past_we      <= i_wb_we;
    past_cyc_err <= i_wb_cyc && i_wb_err;
    past_addr    <= i_wb_addr;
    past_data    <= i_wb_data;
    past_sel     <= i_wb_sel;

    if (i_reset || !i_wb_cyc || i_wb_err) begin
      nreqs <= '0;
      nacks <= '0;
    end else begin
      nreqs <= nreqs + F_LGDEPTH'(accept);
      nacks <= nacks + F_LGDEPTH'(resp);
    end

    if (i_reset || !i_wb_cyc || !i_wb_stb || !i_wb_stall)
      stall_cnt <= '0;
    else
      stall_cnt <= stall_cnt + 32'd1;

    if (i_reset || !i_wb_cyc || i_wb_stb || resp || (f_outstanding == '0))
      ackwait_cnt <= '0;
    else
      ackwait_cnt <= ackwait_cnt + 32'd1;

    // had_stb/stb_fell track whether STB has already dropped inside this CYC
    had_stb  <= !i_reset && i_wb_cyc && (had_stb || i_wb_stb);
    stb_fell <= !i_reset && i_wb_cyc && (stb_fell || (had_stb && !i_wb_stb));
    req_seen <= !i_reset && i_wb_cyc && (req_seen || i_wb_stb);
    if (i_wb_stb)
      req_we <= i_wb_we;

    if (i_reset) begin
      mfault <= 1'b0;
      sfault <= 1'b0;
    end else begin
      mfault <= mfault || mviol;
      sfault <= sfault || sviol;
    end
  end

`ifdef FORMAL
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      assert (!mviol);
      assume (!sviol);
    end
  end
`endif

endmodule

// File: tb/tb_fwb_master.sv
// Directed bench for fwb_master: two monitors with different options watch
// the same stimulus; expected values are hand-derived per scenario.
module tb_fwb_master;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cyc, stb, we, ack, stall, err;
  logic [31:0] addr, data, idata;
  logic [3:0]  sel;

  logic [4:0]  a_nreqs, a_nacks, a_out, b_nreqs, b_nacks, b_out;
  logic        a_mf, a_sf, b_mf, b_sf;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk = ~clk;

  fwb_master #(
    .AW(32), .DW(32), .F_LGDEPTH(5), .F_MAX_STALL(2), .F_MAX_ACK_DELAY(0),
    .F_OPT_RMW_BUS_OPTION(1), .F_OPT_DISCONTINUOUS(0)
  ) dut_a (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack),
    .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
    .f_nreqs(a_nreqs), .f_nacks(a_nacks), .f_outstanding(a_out),
    .o_mfault(a_mf), .o_sfault(a_sf)
  );

  fwb_master #(
    .AW(32), .DW(32), .F_LGDEPTH(5), .F_MAX_STALL(0), .F_MAX_ACK_DELAY(2),
    .F_OPT_RMW_BUS_OPTION(0), .F_OPT_DISCONTINUOUS(1)
  ) dut_b (
    .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc), .i_wb_stb(stb), .i_wb_we(we),
    .i_wb_addr(addr), .i_wb_data(data), .i_wb_sel(sel), .i_wb_ack(ack),
    .i_wb_stall(stall), .i_wb_idata(idata), .i_wb_err(err),
    .f_nreqs(b_nreqs), .f_nacks(b_nacks), .f_outstanding(b_out),
    .o_mfault(b_mf), .o_sfault(b_sf)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cyc = 0; stb = 0; we = 0; ack = 0; stall = 0; err = 0;
    addr = '0; data = '0; sel = '0; idata = '0;
  endtask

  task automatic do_reset();
    idle();
    rst = 1; tick();
    rst = 0; tick();
  endtask

  initial begin
    idle();
    rst = 1; tick(); tick();
    rst = 0; tick();
    check("rst_nreqs", a_nreqs, 0);
    check("rst_nacks", a_nacks, 0);
    check("rst_mfault", a_mf, 0);
    check("rst_sfault", a_sf, 0);

    // single read
    cyc = 1; stb = 1; addr = 32'h100; sel = 4'hf; tick();
    check("rd_nreqs", a_nreqs, 1);
    stb = 0; ack = 1;
    check("rd_out_pending", a_out, 1);
    tick();
    ack = 0;
    check("rd_nacks", a_nacks, 1);
    check("rd_out_done", a_out, 0);
    cyc = 0; tick();
    check("rd_cyc_drop_nreqs", a_nreqs, 0);
    check("rd_mfault", a_mf, 0);
    check("rd_sfault", a_sf, 0);

    // 16-deep pipelined burst, acks lag by one cycle
    cyc = 1;
    for (int i = 0; i < 16; i++) begin
      stb = 1; addr = 32'h200 + 32'(i * 4); ack = (i > 0); tick();
    end
    check("burst_mid_nacks", a_nacks, 15);
    stb = 0; ack = 1; tick();
    ack = 0;
    check("burst_nreqs", a_nreqs, 16);
    check("burst_nacks", a_nacks, 16);
    check("burst_out", a_out, 0);
    cyc = 0; tick();
    check("burst_clr_nreqs", a_nreqs, 0);
    check("burst_clr_nacks", a_nacks, 0);
    check("burst_mfault", a_mf, 0);
    check("burst_sfault", a_sf, 0);

    // stall run of 2: allowed
    cyc = 1; stb = 1; stall = 1; addr = 32'h20; tick(); tick();
    stall = 0; tick();
    stb = 0; ack = 1; tick();
    ack = 0; cyc = 0; tick();
    check("stall2_sfault", a_sf, 0);
    check("stall2_mfault", a_mf, 0);

    // stall run of 3: exceeds limit on dut_a only
    cyc = 1; stb = 1; stall = 1; addr = 32'h24; tick(); tick(); tick();
    stall = 0; tick();
    stb = 0; ack = 1; tick();
    ack = 0; cyc = 0; tick();
    check("stall3_a_sfault", a_sf, 1);
    check("stall3_b_sfault", b_sf, 0);
    check("stall3_a_mfault", a_mf, 0);
    do_reset();
    check("stall3_rst_sfault", a_sf, 0);

    // address changed while stalled
    cyc = 1; stb = 1; stall = 1; addr = 32'h10; tick();
    addr = 32'h14; stall = 0; tick();
    check("addrchg_a_mfault", a_mf, 1);
    check("addrchg_b_mfault", b_mf, 1);
    stb = 0; ack = 1; tick();
    ack = 0; cyc = 0; tick(); tick();
    check("addrchg_sticky", a_mf, 1);
    check("addrchg_sfault", a_sf, 0);
    do_reset();
    check("addrchg_rst_mfault", a_mf, 0);

    // ACK with nothing outstanding
    cyc = 1; tick();
    ack = 1; tick();
    ack = 0; cyc = 0; tick();
    check("spur_ack_a_sfault", a_sf, 1);
    check("spur_ack_b_sfault", b_sf, 1);
    do_reset();

    // ACK and ERR together
    cyc = 1; stb = 1; tick();
    stb = 0; ack = 1; err = 1; tick();
    ack = 0; err = 0; cyc = 0; tick();
    check("ackerr_sfault", a_sf, 1);
    check("ackerr_a_mfault", a_mf, 0);
    check("ackerr_b_mfault", b_mf, 0);
    do_reset();

    // STB 1,0,1 within one CYC
    cyc = 1; stb = 1; tick();
    stb = 0; ack = 1; tick();
    stb = 1; ack = 0; tick();
    stb = 0; ack = 1; tick();
    ack = 0; cyc = 0; tick();
    check("discont_a_mfault", a_mf, 1);
    check("discont_b_mfault", b_mf, 0);
    check("discont_a_sfault", a_sf, 0);
    check("discont_b_sfault", b_sf, 0);
    do_reset();

    // CYC held after ERR: only the non-RMW monitor objects
    cyc = 1; stb = 1; tick();
    stb = 0; err = 1; tick();
    err = 0;
    check("err_clr_nreqs", a_nreqs, 0);
    check("err_out", a_out, 0);
    tick();
    cyc = 0; tick();
    check("rmw_b_mfault", b_mf, 1);
    check("rmw_a_mfault", a_mf, 0);
    do_reset();

    // ack delay: 3 idle waits exceed limit of 2 on dut_b
    cyc = 1; stb = 1; tick();
    stb = 0; tick(); tick(); tick();
    ack = 1; tick();
    ack = 0; cyc = 0; tick();
    check("ackdly_b_sfault", b_sf, 1);
    check("ackdly_a_sfault", a_sf, 0);
    do_reset();

    // reset mid-transaction
    cyc = 1; stb = 1; tick(); tick();
    check("mid_nreqs", a_nreqs, 2);
    rst = 1; tick();
    check("mid_rst_nreqs", a_nreqs, 0);
    rst = 0; cyc = 0; stb = 0; tick();
    check("mid_rst_mfault", a_mf, 0);
    check("mid_rst_sfault", a_sf, 0);

    // bus active in the cycle right after reset
    rst = 1; tick();
    rst = 0; cyc = 1; stb = 1; tick();
    check("postrst_mfault", a_mf, 1);
    idle(); tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
